// File: rtl/sonic_sight_pkg.sv
// Shared types, default timing constants and the sine-code helper for the
// sonic sight transmit chain.
package sonic_sight_pkg;

    // Transmit period state machine
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BURST  = 2'd1,
        LISTEN = 2'd2
    } state_t;

    // Default configuration
    localparam int DEF_PERIOD_DURATION = 16777216;
    localparam int DEF_BURST_DURATION  = 524288;
    localparam int DEF_SIN_WIDTH       = 17;
    localparam int DEF_ANGLE_STEP_DEG  = 5;
    localparam int DEF_MAX_STEPS       = 12;

    // round(sin(k*deg_per_step) * 2^(width-1)), evaluated at elaboration only.
    // A Taylor series keeps this independent of tool support for $sin; the
    // argument never exceeds pi/2, where 12 terms are far beyond 17-bit accuracy.
    function automatic int sin_code(input int k, input int deg_per_step, input int width);
        real x;
        real term;
        real sum;
        real scale;
        x     = real'(k * deg_per_step) * 3.14159265358979323846 / 180.0;
        term  = x;
        sum   = x;
        scale = 1.0;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        for (int b = 1; b < width; b++) begin
            scale = scale * 2.0;
        end
        return $rtoi(sum * scale + 0.5);
    endfunction

endpackage

// File: rtl/sin_lut.sv
// Combinational |sin| table indexed by sweep step magnitude, Q1.(SIN_WIDTH-1).
module sin_lut
    import sonic_sight_pkg::*;
#(
    parameter int SIN_WIDTH      = DEF_SIN_WIDTH,
    parameter int ANGLE_STEP_DEG = DEF_ANGLE_STEP_DEG,
    parameter int MAX_STEPS      = DEF_MAX_STEPS,
    parameter int IDX_W          = 4
) (
    input  logic [IDX_W-1:0]     mag_i,
    output logic [SIN_WIDTH-1:0] sin_o
);

    logic [SIN_WIDTH-1:0] lut_w [2**IDX_W];

    // Entries past the sweep limit are unreachable and tied to zero so the
    // full index range is always defined.
    for (genvar gi = 0; gi < 2**IDX_W; gi++) begin : g_lut
        if (gi <= MAX_STEPS) begin : g_used
            assign lut_w[gi] = SIN_WIDTH'(sin_code(gi, ANGLE_STEP_DEG, SIN_WIDTH));
        end else begin : g_unused
            assign lut_w[gi] = '0;
        end
    end

    assign sin_o = lut_w[mag_i];

endmodule

// File: rtl/beam_sweep_controller.sv
// Transmit period sequencer with ping-pong beam angle sweep. Each period is a
// burst (tx_enable high) followed by a listen window; the steering angle and its
// sine magnitude change only at period boundaries.
module beam_sweep_controller
    import sonic_sight_pkg::*;
#(
    parameter int PERIOD_DURATION = DEF_PERIOD_DURATION,
    parameter int BURST_DURATION  = DEF_BURST_DURATION,
    parameter int SIN_WIDTH       = DEF_SIN_WIDTH,
    parameter int ANGLE_STEP_DEG  = DEF_ANGLE_STEP_DEG,
    parameter int MAX_STEPS       = DEF_MAX_STEPS
) (
    input  logic                                 clk_in,
    input  logic                                 rst_in,
    input  logic                                 enable,
    input  logic                                 hold,
    output logic [SIN_WIDTH-1:0]                 sin_theta,
    output logic                                 sign_bit,
    output logic signed [$clog2(MAX_STEPS)+1:0]  angle_step,
    output logic                                 tx_enable,
    output logic                                 period_start,
    output logic                                 sweep_done
);

    localparam int AW = $clog2(MAX_STEPS) + 2;
    localparam int CW = $clog2(PERIOD_DURATION) + 1;

    localparam logic [CW-1:0]        BURST_LAST  = CW'(BURST_DURATION - 1);
    localparam logic [CW-1:0]        PERIOD_LAST = CW'(PERIOD_DURATION - 1);
    localparam logic signed [AW-1:0] ANG_MAX     = AW'(MAX_STEPS);
    localparam logic signed [AW-1:0] ANG_MIN     = -ANG_MAX;
    localparam logic signed [AW-1:0] ANG_ONE     = AW'(1);
    localparam logic [SIN_WIDTH-1:0] SIN_RESET   =
        SIN_WIDTH'(sin_code(MAX_STEPS, ANGLE_STEP_DEG, SIN_WIDTH));

    // Refuse configurations with no listen window, no burst, or a sweep past 90 deg
    if (BURST_DURATION >= PERIOD_DURATION || BURST_DURATION == 0 ||
        MAX_STEPS * ANGLE_STEP_DEG > 90) begin : g_bad_cfg
        $error("beam_sweep_controller: invalid burst/period or sweep range");
    end

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic                   tx_q;
    logic                   ps_q;
    logic                   done_q;
    logic signed [AW-1:0]   angle_q;
    logic                   dir_up_q;
    logic                   sign_q;
    logic [SIN_WIDTH-1:0]   sin_q;

    logic signed [AW-1:0]   angle_d;
    logic                   dir_up_d;
    logic                   done_d;
    logic [AW-1:0]          mag_d;
    logic [SIN_WIDTH-1:0]   sin_d;

    // Candidate angle for the next period: one step in the current direction,
    // turning around (and flagging the endpoint) when a limit is reached.
    always_comb begin
        angle_d  = angle_q;
        dir_up_d = dir_up_q;
        done_d   = 1'b0;
        if (!hold) begin
            angle_d = dir_up_q ? (angle_q + ANG_ONE) : (angle_q - ANG_ONE);
            if (angle_d == ANG_MAX) begin
                dir_up_d = 1'b0;
                done_d   = 1'b1;
            end else if (angle_d == ANG_MIN) begin
                dir_up_d = 1'b1;
                done_d   = 1'b1;
            end
        end
        mag_d = angle_d[AW-1] ? AW'(-angle_d) : AW'(angle_d);
    end

    sin_lut #(
        .SIN_WIDTH      (SIN_WIDTH),
        .ANGLE_STEP_DEG (ANGLE_STEP_DEG),
        .MAX_STEPS      (MAX_STEPS),
        .IDX_W          (AW)
    ) u_sin_lut (
        .mag_i (mag_d),
        .sin_o (sin_d)
    );

    // Period FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            tx_q     <= 1'b0;
            ps_q     <= 1'b0;
            done_q   <= 1'b0;
            angle_q  <= ANG_MIN;
            dir_up_q <= 1'b1;
            sign_q   <= 1'b1;
            sin_q    <= SIN_RESET;
        end else begin
            ps_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q <= BURST;
                        cnt_q   <= '0;
                        tx_q    <= 1'b1;
                        ps_q    <= 1'b1;
                    end
                end
                BURST: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == BURST_LAST) begin
                        state_q <= LISTEN;
                        tx_q    <= 1'b0;
                    end
                end
                LISTEN: begin
                    if (cnt_q == PERIOD_LAST) begin
                        // Period boundary: commit the new angle, then restart
                        // or park depending on enable sampled right here.
                        angle_q  <= angle_d;
                        dir_up_q <= dir_up_d;
                        done_q   <= done_d;
                        sign_q   <= angle_d[AW-1];
                        sin_q    <= sin_d;
                        cnt_q    <= '0;
                        if (enable) begin
                            state_q <= BURST;
                            tx_q    <= 1'b1;
                            ps_q    <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b0;
                end
            endcase
        end
    end

    assign sin_theta    = sin_q;
    assign sign_bit     = sign_q;
    assign angle_step   = angle_q;
    assign tx_enable    = tx_q;
    assign period_start = ps_q;
    assign sweep_done   = done_q;

endmodule

// File: tb/tb_beam_sweep_controller.sv
// Directed bench for beam_sweep_controller with a 100-cycle period, 20-cycle
// burst and a 30 deg x 2 step sweep.
module tb_beam_sweep_controller;

    localparam int PER = 100;
    localparam int BUR = 20;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              enable;
    logic              hold;
    logic [16:0]       sin_theta;
    logic              sign_bit;
    logic signed [2:0] angle_step;
    logic              tx_enable;
    logic              period_start;
    logic              sweep_done;

    int total = 0;
    int bad   = 0;

    beam_sweep_controller #(
        .PERIOD_DURATION (PER),
        .BURST_DURATION  (BUR),
        .SIN_WIDTH       (17),
        .ANGLE_STEP_DEG  (30),
        .MAX_STEPS       (2)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .enable       (enable),
        .hold         (hold),
        .sin_theta    (sin_theta),
        .sign_bit     (sign_bit),
        .angle_step   (angle_step),
        .tx_enable    (tx_enable),
        .period_start (period_start),
        .sweep_done   (sweep_done)
    );

    always #5 clk_in = ~clk_in;

    // Reset with enable low, then release with the requested enable level
    task automatic do_reset(input logic en);
        @(negedge clk_in);
        rst_in = 1'b0;
        enable = 1'b0;
        hold   = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        enable = en;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        enable = 1'b0;
        hold   = 1'b0;
        repeat (3) @(negedge clk_in);
        total++; if (tx_enable !== 1'b0) begin bad++; $display("FAIL rst_tx got=%b exp=0", tx_enable); end
        total++; if (period_start !== 1'b0) begin bad++; $display("FAIL rst_ps got=%b exp=0", period_start); end
        total++; if (sweep_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", sweep_done); end
        total++; if (angle_step !== -3'sd2) begin bad++; $display("FAIL rst_angle got=%0d exp=-2", angle_step); end
        total++; if (sign_bit !== 1'b1) begin bad++; $display("FAIL rst_sign got=%b exp=1", sign_bit); end
        total++; if (sin_theta !== 17'd56756) begin bad++; $display("FAIL rst_sin got=%0d exp=56756", sin_theta); end
        $display("reset: angle=%0d sin=%0d sign=%b tx=%b", angle_step, sin_theta, sign_bit, tx_enable);
    endtask

    task automatic test_timing();
        bit found = 0;
        do_reset(1'b1);
        for (int i = 0; i < 10; i++) begin
            if (period_start === 1'b1) begin found = 1; break; end
            @(negedge clk_in);
        end
        total++; if (!found) begin bad++; $display("FAIL timing_start got=no_period_start exp=period_start"); end
        for (int p = 0; p < 2; p++) begin
            int tx_cnt = 0;
            int ps_cnt = 0;
            int pat_err = 0;
            for (int c = 0; c < PER; c++) begin
                if (tx_enable !== (c < BUR)) pat_err++;
                if (period_start !== (c == 0)) pat_err++;
                if (tx_enable === 1'b1) tx_cnt++;
                if (period_start === 1'b1) ps_cnt++;
                @(negedge clk_in);
            end
            total++; if (tx_cnt != BUR) begin bad++; $display("FAIL timing_tx_len p=%0d got=%0d exp=%0d", p, tx_cnt, BUR); end
            total++; if (ps_cnt != 1) begin bad++; $display("FAIL timing_ps_count p=%0d got=%0d exp=1", p, ps_cnt); end
            total++; if (pat_err != 0) begin bad++; $display("FAIL timing_pattern p=%0d got=%0d_bad_cycles exp=0", p, pat_err); end
            $display("timing period %0d: tx_cycles=%0d period_starts=%0d", p, tx_cnt, ps_cnt);
        end
        total++; if (period_start !== 1'b1) begin bad++; $display("FAIL timing_next_ps got=%b exp=1", period_start); end
    endtask

    task automatic test_sweep();
        int exp_ang [9] = '{-2, -1, 0, 1, 2, 1, 0, -1, -2};
        int exp_sin [9] = '{56756, 32768, 0, 32768, 56756, 32768, 0, 32768, 56756};
        int exp_done[9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
        bit found = 0;
        logic signed [2:0] ea;
        do_reset(1'b1);
        for (int i = 0; i < 10; i++) begin
            if (period_start === 1'b1) begin found = 1; break; end
            @(negedge clk_in);
        end
        total++; if (!found) begin bad++; $display("FAIL sweep_start got=no_period_start exp=period_start"); end
        for (int p = 0; p < 9; p++) begin
            ea = 3'(exp_ang[p]);
            total++; if (period_start !== 1'b1) begin bad++; $display("FAIL sweep_ps p=%0d got=%b exp=1", p, period_start); end
            total++; if (angle_step !== ea) begin bad++; $display("FAIL sweep_angle p=%0d got=%0d exp=%0d", p, angle_step, ea); end
            total++; if (sin_theta !== 17'(exp_sin[p])) begin bad++; $display("FAIL sweep_sin p=%0d got=%0d exp=%0d", p, sin_theta, exp_sin[p]); end
            total++; if (sign_bit !== (exp_ang[p] < 0)) begin bad++; $display("FAIL sweep_sign p=%0d got=%b exp=%b", p, sign_bit, exp_ang[p] < 0); end
            total++; if (sweep_done !== 1'(exp_done[p])) begin bad++; $display("FAIL sweep_done p=%0d got=%b exp=%0d", p, sweep_done, exp_done[p]); end
            $display("sweep period %0d: angle=%0d sin=%0d sign=%b done=%b", p, angle_step, sin_theta, sign_bit, sweep_done);
            @(negedge clk_in);
            total++; if (sweep_done !== 1'b0) begin bad++; $display("FAIL sweep_done_pulse p=%0d got=%b exp=0", p, sweep_done); end
            repeat (PER / 2) @(negedge clk_in);
            total++; if (angle_step !== ea) begin bad++; $display("FAIL sweep_angle_mid p=%0d got=%0d exp=%0d", p, angle_step, ea); end
            repeat (PER - 1 - PER / 2) @(negedge clk_in);
        end
    endtask

    task automatic test_hold();
        int exp_ang[5] = '{-2, -1, -1, -1, 0};
        bit found = 0;
        logic signed [2:0] ea;
        do_reset(1'b1);
        for (int i = 0; i < 10; i++) begin
            if (period_start === 1'b1) begin found = 1; break; end
            @(negedge clk_in);
        end
        total++; if (!found) begin bad++; $display("FAIL hold_start got=no_period_start exp=period_start"); end
        for (int p = 0; p < 5; p++) begin
            ea = 3'(exp_ang[p]);
            total++; if (angle_step !== ea) begin bad++; $display("FAIL hold_angle p=%0d got=%0d exp=%0d", p, angle_step, ea); end
            total++; if (sweep_done !== 1'b0) begin bad++; $display("FAIL hold_done p=%0d got=%b exp=0", p, sweep_done); end
            $display("hold period %0d: hold=%b angle=%0d sin=%0d", p, hold, angle_step, sin_theta);
            repeat (10) @(negedge clk_in);
            if (p == 1) hold = 1'b1;
            if (p == 3) hold = 1'b0;
            repeat (PER - 10) @(negedge clk_in);
        end
    endtask

    task automatic test_disable();
        bit found = 0;
        int tx_cnt = 0;
        int ps_after = 0;
        int tx_after = 0;
        do_reset(1'b1);
        for (int i = 0; i < 10; i++) begin
            if (period_start === 1'b1) begin found = 1; break; end
            @(negedge clk_in);
        end
        total++; if (!found) begin bad++; $display("FAIL dis_start got=no_period_start exp=period_start"); end
        for (int c = 0; c < PER; c++) begin
            if (c == 5) enable = 1'b0;
            if (tx_enable === 1'b1) tx_cnt++;
            @(negedge clk_in);
        end
        total++; if (tx_cnt != BUR) begin bad++; $display("FAIL dis_burst_len got=%0d exp=%0d", tx_cnt, BUR); end
        for (int c = 0; c < 150; c++) begin
            if (period_start === 1'b1) ps_after++;
            if (tx_enable === 1'b1) tx_after++;
            @(negedge clk_in);
        end
        total++; if (ps_after != 0) begin bad++; $display("FAIL dis_no_restart got=%0d exp=0", ps_after); end
        total++; if (tx_after != 0) begin bad++; $display("FAIL dis_tx_idle got=%0d exp=0", tx_after); end
        $display("disable: burst_cycles=%0d later_period_starts=%0d later_tx_cycles=%0d", tx_cnt, ps_after, tx_after);
    endtask

    task automatic test_reset_mid_burst();
        bit found = 0;
        int tx_cnt = 0;
        do_reset(1'b1);
        for (int i = 0; i < 10; i++) begin
            if (period_start === 1'b1) begin found = 1; break; end
            @(negedge clk_in);
        end
        total++; if (!found) begin bad++; $display("FAIL rmb_start got=no_period_start exp=period_start"); end
        repeat (PER + 10) @(negedge clk_in);
        total++; if (angle_step !== -3'sd1) begin bad++; $display("FAIL rmb_pre_angle got=%0d exp=-1", angle_step); end
        total++; if (tx_enable !== 1'b1) begin bad++; $display("FAIL rmb_pre_tx got=%b exp=1", tx_enable); end
        rst_in = 1'b0;
        #1;
        total++; if (tx_enable !== 1'b0) begin bad++; $display("FAIL rmb_tx got=%b exp=0", tx_enable); end
        total++; if (angle_step !== -3'sd2) begin bad++; $display("FAIL rmb_angle got=%0d exp=-2", angle_step); end
        total++; if (sin_theta !== 17'd56756) begin bad++; $display("FAIL rmb_sin got=%0d exp=56756", sin_theta); end
        $display("reset mid-burst: tx=%b angle=%0d sin=%0d", tx_enable, angle_step, sin_theta);
        @(negedge clk_in);
        rst_in = 1'b1;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            if (period_start === 1'b1) begin found = 1; break; end
            @(negedge clk_in);
        end
        total++; if (!found) begin bad++; $display("FAIL rmb_restart got=no_period_start exp=period_start"); end
        total++; if (tx_enable !== 1'b1) begin bad++; $display("FAIL rmb_first_tx got=%b exp=1", tx_enable); end
        for (int c = 0; c < PER; c++) begin
            if (tx_enable === 1'b1) tx_cnt++;
            @(negedge clk_in);
        end
        total++; if (tx_cnt != BUR) begin bad++; $display("FAIL rmb_burst_len got=%0d exp=%0d", tx_cnt, BUR); end
        $display("reset mid-burst restart: burst_cycles=%0d", tx_cnt);
    endtask

    initial begin
        test_reset();
        test_timing();
        test_sweep();
        test_hold();
        test_disable();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/beam_sweep_controller.md
BEAM_SWEEP_CONTROLLER -- requirements
Module: beam_sweep_controller

Interface
REQ-001 SHALL have parameter PERIOD_DURATION, default 16777216: clock cycles per transmit period (burst plus listen).
REQ-002 SHALL have parameter BURST_DURATION, default 524288: clock cycles per period that tx_enable is high.
REQ-003 SHALL have parameter SIN_WIDTH, default 17: width of unsigned sin magnitude, Q1.(SIN_WIDTH-1).
REQ-004 SHALL have parameter ANGLE_STEP_DEG, default 5: degrees per sweep step.
REQ-005 SHALL have parameter MAX_STEPS, default 12: sweep limit in steps, giving +/-60 deg at default.
REQ-006 SHALL have port clk_in, input, 1: the single system clock.
REQ-007 SHALL have port rst_in, input, 1: reset, asynchronous and active-low.
REQ-008 SHALL have port enable, input, 1: run sweep.
REQ-009 SHALL have port hold, input, 1: freeze angle at period boundaries.
REQ-010 SHALL have port sin_theta, output, SIN_WIDTH: |sin(angle)| to the transmit beamformer.
REQ-011 SHALL have port sign_bit, output, 1: 1 when angle < 0.
REQ-012 SHALL have port angle_step, output, $clog2(MAX_STEPS)+2, signed: current angle in steps.
REQ-013 SHALL have port tx_enable, output, 1: burst gate for the transmitters.
REQ-014 SHALL have port period_start, output, 1: one-cycle pulse on the first cycle of each period.
REQ-015 SHALL have port sweep_done, output, 1: one-cycle pulse when the angle reaches either sweep endpoint.

Function
REQ-016 SHALL implement an FSM with three states, IDLE, BURST and LISTEN, plus one period counter of width $clog2(PERIOD_DURATION)+1.
REQ-017 SHALL, in IDLE with enable=1, enter BURST on the next edge, clear the counter, and assert period_start during that first BURST cycle.
REQ-018 SHALL hold tx_enable=1 exactly in BURST, for exactly BURST_DURATION cycles, then go to LISTEN.
REQ-019 SHALL, in LISTEN, on the cycle where the counter equals PERIOD_DURATION-1: update the angle (REQ-021), then go to BURST if enable=1 (period_start again) or to IDLE otherwise.
REQ-020 SHALL sample enable only at period boundaries, so that deasserting it mid-period completes that period and never truncates a burst.
REQ-021 SHALL update the angle by ping-pong stepping between -MAX_STEPS and +MAX_STEPS by +/-1 per period in the current direction; on reaching an endpoint it SHALL reverse direction and pulse sweep_done coincident with period_start of the period that uses the endpoint angle.
REQ-022 SHALL leave angle and direction unchanged at a boundary when hold=1.
REQ-023 SHALL register sin_theta, sign_bit and angle_step, holding them constant for the whole period; new values SHALL appear in the same cycle as period_start.
REQ-024 SHALL set sin_theta = LUT[|angle_step|], where LUT[k] = round(sin(k*ANGLE_STEP_DEG deg) * 2^(SIN_WIDTH-1)), and sign_bit = (angle_step < 0); angle 0 gives sin_theta=0 and sign_bit=0.
REQ-025 SHALL reject at elaboration any configuration where BURST_DURATION >= PERIOD_DURATION, BURST_DURATION = 0, or MAX_STEPS*ANGLE_STEP_DEG > 90.

Reset
REQ-026 SHALL, while rst_in=0, immediately force: state=IDLE, counter=0, tx_enable=0, period_start=0, sweep_done=0, angle_step=-MAX_STEPS, direction=up, sign_bit=1, sin_theta=LUT[MAX_STEPS].
REQ-027 SHALL abort any in-progress burst immediately on reset, with tx_enable low in the same cycle, and resume only through REQ-017 after release.

Structure
REQ-028 SHALL define the FSM state enum, SIN_WIDTH and the default timing constants in the shared package sonic_sight_pkg.
REQ-029 SHALL place the sine table in a combinational sub-module sin_lut, parameterised by SIN_WIDTH, ANGLE_STEP_DEG and MAX_STEPS and indexed by step magnitude.

Verification
REQ-030 SHALL verify basic timing: with PERIOD_DURATION=100, BURST_DURATION=20, enable=1 from reset release, tx_enable SHALL be high 20 cycles then low 80, and period_start SHALL pulse every 100 cycles.
REQ-031 SHALL verify the sweep: with ANGLE_STEP_DEG=30 and MAX_STEPS=2, successive periods SHALL give angle_step -2,-1,0,1,2,1,0,-1,-2 and sin_theta 56756,32768,0,32768,56756,...; sign_bit=1 only for negative angles; sweep_done SHALL pulse at angles +2 and -2.
REQ-032 SHALL verify hold: asserting hold=1 during the angle -1 period SHALL keep angle -1 for all following periods, and releasing it SHALL resume at 0.
REQ-033 SHALL verify graceful disable: enable dropped at cycle 5 of a burst SHALL complete the 20-cycle burst and 80-cycle listen, then IDLE with tx_enable=0 and no further period_start.
REQ-034 SHALL verify reset mid-burst: rst_in low at burst cycle 10 SHALL drop tx_enable immediately and restore angle_step=-2 and sin_theta=56756; after release, the first period SHALL be a full 20-cycle burst.
